// File: rtl/pc_unit_if.sv
// Fetch-side bundle for the program-counter unit: redirect/stall/halt inputs,
// imem handshake and the PC/history outputs consumed by later stages.
interface pc_unit_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned HIST_DEPTH = 2
);
  logic                       next_sel;
  logic                       branch_result;
  logic [XLEN-1:0]            next_address;
  logic                       trap_req;
  logic                       load;
  logic                       dmem_valid;
  logic                       halt;
  logic                       imem_ready;
  logic                       imem_valid;
  logic [XLEN-1:0]            address_out;
  logic [XLEN-1:0]            pre_address_pc;
  logic [XLEN*HIST_DEPTH-1:0] pc_hist;
  logic                       redirect_taken;
  logic                       misaligned;
  logic [1:0]                 state;

  // PC unit side
  modport master (
    input  next_sel, branch_result, next_address, trap_req, load,
           dmem_valid, halt, imem_ready,
    output imem_valid, address_out, pre_address_pc, pc_hist,
           redirect_taken, misaligned, state
  );

  // Core / memory side
  modport slave (
    output next_sel, branch_result, next_address, trap_req, load,
           dmem_valid, halt, imem_ready,
    input  imem_valid, address_out, pre_address_pc, pc_hist,
           redirect_taken, misaligned, state
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the RV32I fetch stage: sequential stepping with
// imem backpressure, prioritised redirects with misalignment trap, load stall,
// halt state and a shift-register history of previous PCs.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     HIST_DEPTH   = 2
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            redir_q, redir_d;
  logic            mis_q, mis_d;
  logic            shift;
  logic            stall;
  logic            jump;
  logic            aligned;
  logic [XLEN-1:0] hist_q [HIST_DEPTH];

  assign stall   = bus.load && !bus.dmem_valid;
  assign jump    = bus.next_sel || bus.branch_result;
  assign aligned = (bus.next_address & ALIGN_MASK) == '0;

  // Fetch request: only in RUN and not stalled on an outstanding load
  always_comb begin
    bus.imem_valid = (state_q == RUN) && !stall;
  end

  // Next-state / next-PC selection in priority order
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = 1'b0;
    mis_d   = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.trap_req) begin
          pc_d    = TRAP_VECTOR;
          redir_d = 1'b1;
          shift   = 1'b1;
        end else if (jump) begin
          // Redirects flush: they ignore both the stall and imem_ready
          pc_d    = aligned ? bus.next_address : TRAP_VECTOR;
          redir_d = 1'b1;
          mis_d   = !aligned;
          shift   = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (bus.halt) begin
          state_d = HALT;
        end else if (bus.imem_ready) begin
          // imem_valid is implied here: RUN and no stall
          pc_d  = pc_q + STEP_INC;
          shift = 1'b1;
        end
      end
      HALT: begin
        // Trap wakes the unit; history is frozen while halted
        if (bus.trap_req) begin
          pc_d    = TRAP_VECTOR;
          redir_d = 1'b1;
          state_d = RUN;
        end else if (!bus.halt) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC and registered event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      redir_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      mis_q   <= mis_d;
    end
  end

  // History shift register, newest entry at index 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
        hist_q[k] <= '0;
      end
    end else if (shift) begin
      hist_q[0] <= pc_q;
      for (int unsigned k = 1; k < HIST_DEPTH; k++) begin
        hist_q[k] <= hist_q[k-1];
      end
    end
  end

  // Flatten history onto the output bus
  always_comb begin
    bus.pc_hist = '0;
    for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
      bus.pc_hist[k*XLEN +: XLEN] = hist_q[k];
    end
  end

  assign bus.address_out    = pc_q;
  assign bus.pre_address_pc = hist_q[0];
  assign bus.redirect_taken = redir_q;
  assign bus.misaligned     = mis_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver applies stimulus at the falling edge
// and pushes the reference model's expected post-edge outputs; a monitor pops
// and compares shortly after each rising edge (or on demand for async reset).
module tb_pc_unit;
  localparam int unsigned     XLEN = 32;
  localparam int unsigned     HD   = 2;
  localparam logic [31:0]     RV   = 32'h0000_0000;
  localparam logic [31:0]     TV   = 32'h0000_0100;
  localparam int unsigned     STEP = 4;
  localparam int unsigned     AB   = 2;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      pre;
    logic [XLEN*HD-1:0] hist;
    logic             redir;
    logic             mis;
    logic [1:0]       st;
    logic             iv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(XLEN), .HIST_DEPTH(HD)) bus ();

  pc_unit #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV),
    .STEP(STEP), .ALIGN_BITS(AB), .HIST_DEPTH(HD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  // Reference model: 0=BOOT 1=RUN 2=HALT, history as a queue of addresses
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_hist[$];
  bit          m_redir, m_mis;

  task automatic model_reset();
    m_state = 0;
    m_pc    = RV;
    m_hist.delete();
    for (int i = 0; i < HD; i++) m_hist.push_back(32'h0);
    m_redir = 0;
    m_mis   = 0;
  endtask

  task automatic move_to(input logic [31:0] target, input bit record);
    if (record) begin
      m_hist.push_front(m_pc);
      void'(m_hist.pop_back());
    end
    m_pc = target;
  endtask

  task automatic model_step(input bit ns, br, trap, ld, dv, hlt, rdy,
                            input logic [31:0] na);
    m_redir = 0;
    m_mis   = 0;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (trap) begin
          move_to(TV, 1); m_redir = 1;
        end else if (ns || br) begin
          m_redir = 1;
          if ((na % (32'd1 << AB)) == 0) move_to(na, 1);
          else begin move_to(TV, 1); m_mis = 1; end
        end else if (ld && !dv) begin
          // stalled: nothing moves
        end else if (hlt) begin
          m_state = 2;
        end else if (rdy) begin
          move_to(32'((64'(m_pc) + STEP) % 64'h1_0000_0000), 1);
        end
      end
      default: begin
        if (trap) begin
          move_to(TV, 0); m_redir = 1; m_state = 1;
        end else if (!hlt) begin
          m_state = 1;
        end
      end
    endcase
  endtask

  function automatic exp_t model_out(input bit ld, dv);
    exp_t e;
    e.pc    = m_pc;
    e.pre   = m_hist[0];
    e.hist  = '0;
    for (int k = 0; k < HD; k++) e.hist[k*32 +: 32] = m_hist[k];
    e.redir = m_redir;
    e.mis   = m_mis;
    e.st    = 2'(m_state);
    e.iv    = (m_state == 1) && !(ld && !dv);
    return e;
  endfunction

  // One clock of stimulus; called at a falling edge, returns at the next one
  task automatic cycle(input bit ns, br, trap, ld, dv, hlt, rdy,
                       input logic [31:0] na);
    bus.next_sel      = ns;
    bus.branch_result = br;
    bus.trap_req      = trap;
    bus.load          = ld;
    bus.dmem_valid    = dv;
    bus.halt          = hlt;
    bus.imem_ready    = rdy;
    bus.next_address  = na;
    model_step(ns, br, trap, ld, dv, hlt, rdy, na);
    q.push_back(model_out(ld, dv));
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 0, 0, 0, 0, rdy, 32'h0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #1 -> sample_ev;
  end

  // Monitor: compare DUT outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("address_out",    64'(bus.address_out),    64'(e.pc));
        chk("pre_address_pc", 64'(bus.pre_address_pc), 64'(e.pre));
        chk("pc_hist",        64'(bus.pc_hist),        64'(e.hist));
        chk("redirect_taken", 64'(bus.redirect_taken), 64'(e.redir));
        chk("misaligned",     64'(bus.misaligned),     64'(e.mis));
        chk("state",          64'(bus.state),          64'(e.st));
        chk("imem_valid",     64'(bus.imem_valid),     64'(e.iv));
      end
    end
  end

  // Driver
  initial begin
    logic [31:0] na;
    bus.next_sel = 0; bus.branch_result = 0; bus.trap_req = 0; bus.load = 0;
    bus.dmem_valid = 0; bus.halt = 0; bus.imem_ready = 0; bus.next_address = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    q.push_back(model_out(0, 0));
    -> sample_ev;
    #1;
    @(negedge clk);
    rst = 1'b0;

    // BOOT then sequential fetch 0,4,8,12,16
    repeat (5) idle(1);
    // Branch at 0x10 overrides stall and backpressure
    cycle(0, 1, 0, 1, 0, 0, 0, 32'h40);
    idle(0);
    // Misaligned jump, then the same with a trap taking precedence
    cycle(1, 0, 0, 0, 0, 0, 1, 32'h42);
    cycle(1, 0, 1, 0, 0, 0, 1, 32'h42);
    // Load stall at 0x20
    cycle(0, 1, 0, 0, 0, 0, 1, 32'h20);
    repeat (3) cycle(0, 0, 0, 1, 0, 0, 1, 32'h0);
    cycle(0, 0, 0, 1, 1, 0, 1, 32'h0);
    // Halt at 0x30; branch ignored; trap wakes
    cycle(0, 1, 0, 0, 0, 0, 1, 32'h30);
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h0);
    cycle(0, 1, 0, 0, 0, 1, 1, 32'h80);
    cycle(0, 0, 1, 0, 0, 1, 1, 32'h0);
    // Halt released by dropping the request
    cycle(0, 0, 0, 0, 0, 1, 1, 32'h0);
    idle(1);
    idle(1);
    // Wrap-around at the top of the address space
    cycle(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    idle(1);
    idle(1);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    q.push_back(model_out(0, 0));
    #1 -> sample_ev;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      na = $urandom;
      if ($urandom_range(3) != 0) na[1:0] = 2'b00;
      cycle($urandom_range(9) == 0, $urandom_range(9) == 0,
            $urandom_range(19) == 0, $urandom_range(3) == 0,
            $urandom_range(1) == 0, $urandom_range(11) == 0,
            $urandom_range(3) != 0, na);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
